// File: rtl/wb_prog_loader.sv
// wb_prog_loader
//   Wishbone classic initiator used at boot to stream a program image into the
//   uP16 memory banks. Bytes arrive on a valid/ready port. Each byte pair is
//   packed into a 16-bit word, low byte first. Each word is written with one
//   single-beat cycle, at ADDR_BASE + 4*index.
//   Optional build macro: LOADER_READBACK_EN. When it is defined, every acked
//   write is followed by a read of the same address, and the word is compared
//   with the value read back.

module wb_prog_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          LEN_W     = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The counter starts at 0 when the request is issued. Terminal value
    // TIMEOUT-1 therefore gives exactly TIMEOUT cycles with strobe high.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_REQ, S_WAIT, S_DONE, S_RREQ, S_RWAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LO, S_HI, S_REQ, S_WAIT, S_DONE
    } state_t;
`endif

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] index;
    logic [15:0]      word;
    logic [15:0]      tmo_cnt;
    logic             armed;

    logic [LEN_W-1:0] idx_nxt;
    logic             last_word;
    logic [31:0]      adr_nxt;

    assign idx_nxt   = index + LEN_W'(1);
    assign last_word = (idx_nxt == len_q);
    assign adr_nxt   = ADDR_BASE + 32'({index, 2'b00});

    // Bytes are consumed only while a word is being assembled.
    assign byte_ready = (state == S_LO) || (state == S_HI);

`ifdef LOADER_READBACK_EN
    // Only the low half-word is compared. The upper half of the read bus is not used.
    logic unused_rd;
    assign unused_rd = ^wbm_dat_i[31:16];
`else
    // Without readback, the read bus has no consumer.
    logic unused_rd;
    assign unused_rd = ^wbm_dat_i;
`endif

    // Loader sequencer: byte packing, bus cycles, timeout and status flags.
    // NOTE: all state and outputs below are updated with non-blocking
    // assignments. Every register then samples the pre-edge values of the
    // others, whatever order the statements are written in.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            index     <= '0;
            word      <= '0;
            tmo_cnt   <= '0;
            armed     <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // armed stays low during the first edge after reset release. A start
            // on the same edge as reset release is therefore never taken.
            armed <= 1'b1;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        err   <= 1'b0;
                        index <= '0;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_q <= len;
                            busy  <= 1'b1;
                            state <= S_LO;
                        end
                    end
                end

                S_LO: begin
                    if (byte_valid) begin
                        word[7:0] <= byte_data;
                        state     <= S_HI;
                    end
                end

                S_HI: begin
                    if (byte_valid) begin
                        word[15:8] <= byte_data;
                        state      <= S_REQ;
                    end
                end

                S_REQ: begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= 4'b0011;
                    wbm_adr_o <= adr_nxt;
                    wbm_dat_o <= {16'h0000, word};
                    tmo_cnt   <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
`ifdef LOADER_READBACK_EN
                        state     <= S_RREQ;
`else
                        index     <= idx_nxt;
                        state     <= last_word ? S_DONE : S_LO;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

`ifdef LOADER_READBACK_EN
                S_RREQ: begin
                    // The address register still holds the address of the write.
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= 4'b0011;
                    tmo_cnt   <= '0;
                    state     <= S_RWAIT;
                end

                S_RWAIT: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        if (wbm_dat_i[15:0] != word) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            index <= idx_nxt;
                            state <= last_word ? S_DONE : S_LO;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
`endif

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                // NOTE: the default arm puts any unreachable encoding back in
                // IDLE, so the decoder is full and no stray state can persist.
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader
//   Directed bench for wb_prog_loader. A byte feeder drives the stream from a
//   queue. A Wishbone slave model acks after a programmable number of wait
//   cycles, or never. A monitor logs completed transfers and bus-protocol
//   violations.
//   The bench can also be built with LOADER_READBACK_EN defined.

module tb_wb_prog_loader;

`ifdef LOADER_READBACK_EN
    localparam int XFER_PER_WORD = 2;
`else
    localparam int XFER_PER_WORD = 1;
`endif
    localparam int CYC_PER_WORD = 4 + 2 * (XFER_PER_WORD - 1);

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        ack;
    logic        busy, done, err;

    wb_prog_loader #(
        .ADDR_BASE(32'h3000_0000),
        .LEN_W    (12),
        .TIMEOUT  (255)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .start     (start),
        .len       (len),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Single comparison point; every check in the bench goes through here.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          ack_delay = 0;   // wait cycles before ack; negative = never
    int          stall_cnt = 0;
    logic [31:0] last_wr   = '0;
    logic [15:0] corrupt   = '0;

    assign ack       = wbm_cyc_o && wbm_stb_o && (ack_delay >= 0) && (stall_cnt >= ack_delay);
    assign wbm_dat_i = {16'h0000, last_wr[15:0] ^ corrupt};

    // Counts stalled strobe cycles for the current transfer.
    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !ack) stall_cnt <= stall_cnt + 1;
        else                                stall_cnt <= 0;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // ---------------- byte feeder ----------------
    logic [7:0] bq[$];
    bit         toggle_mode = 0;
    bit         toggle_ph   = 0;
    bit         last_hs     = 0;
    int         first_hs    = -1;

    initial begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (last_hs && bq.size() > 0) bq.delete(0);
            if (bq.size() > 0 && (!toggle_mode || toggle_ph)) begin
                byte_valid = 1'b1;
                byte_data  = bq[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'h00;
            end
            toggle_ph = !toggle_ph;
            last_hs   = byte_valid && byte_ready;
            if (last_hs && first_hs < 0) first_hs = cyc_n + 1;
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic [3:0]  wr_sel[$];
    logic [31:0] rd_adr[$];
    int          cyc_cycles   = 0;
    int          ready_in_bus = 0;
    int          unstable     = 0;
    int          done_cnt     = 0;
    int          first_done   = -1;
    bit          prev_pending = 0;
    logic [31:0] prev_adr, prev_dat;
    logic        prev_we;

    initial begin
        forever begin
            @(negedge clk);
            if (wbm_cyc_o) cyc_cycles++;
            if (wbm_cyc_o && byte_ready) ready_in_bus++;
            if (prev_pending && wbm_cyc_o && wbm_stb_o &&
                (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat || wbm_we_o !== prev_we))
                unstable++;
            if (wbm_cyc_o && wbm_stb_o && ack) begin
                if (wbm_we_o) begin
                    wr_adr.push_back(wbm_adr_o);
                    wr_dat.push_back(wbm_dat_o);
                    wr_sel.push_back(wbm_sel_o);
                    last_wr = wbm_dat_o;
                end else begin
                    rd_adr.push_back(wbm_adr_o);
                end
            end
            prev_pending = wbm_cyc_o && wbm_stb_o && !ack;
            prev_adr     = wbm_adr_o;
            prev_dat     = wbm_dat_o;
            prev_we      = wbm_we_o;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc_n;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_stats();
        cyc_cycles   = 0;
        ready_in_bus = 0;
        unstable     = 0;
        done_cnt     = 0;
        first_done   = -1;
        first_hs     = -1;
        wr_adr.delete();
        wr_dat.delete();
        wr_sel.delete();
        rd_adr.delete();
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic pulse_start(input logic [11:0] n);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_quiet(input int max_cyc, input string tag);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy && !wbm_cyc_o) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_finished"}, 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] exp_w[3];
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy, done, err, byte_ready}, '0);
        check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // len=3, zero-wait slave, continuous bytes
        clear_stats();
        ack_delay = 0; toggle_mode = 0;
        bq = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        exp_w = '{16'h1234, 16'h5678, 16'h9ABC};
        pulse_start(12'd3);
        check("t1_busy", 64'(busy), 64'd1);
        wait_quiet(200, "t1");
        check("t1_wr_count", 64'(wr_adr.size()), 64'd3);
        for (int i = 0; i < 3 && i < wr_adr.size(); i++) begin
            check($sformatf("t1_adr%0d", i), 64'(wr_adr[i]), 64'(32'h3000_0000 + 32'(4 * i)));
            check($sformatf("t1_dat%0d", i), 64'(wr_dat[i]), 64'({16'h0000, exp_w[i]}));
            check($sformatf("t1_sel%0d", i), 64'(wr_sel[i]), 64'd3);
        end
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_done_latency", 64'(first_done - first_hs), 64'(3 * CYC_PER_WORD));
        check("t1_err", 64'(err), 64'd0);

        // len=2, 3 wait states, bytes every other cycle
        clear_stats();
        ack_delay = 3; toggle_mode = 1;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start(12'd2);
        wait_quiet(300, "t2");
        check("t2_wr_count", 64'(wr_adr.size()), 64'd2);
        if (wr_adr.size() == 2) begin
            check("t2_w0", {wr_adr[0], wr_dat[0]}, {32'h3000_0000, 32'h0000_2211});
            check("t2_w1", {wr_adr[1], wr_dat[1]}, {32'h3000_0004, 32'h0000_4433});
        end
        check("t2_unstable", 64'(unstable), 64'd0);
        check("t2_ready_in_bus", 64'(ready_in_bus), 64'd0);
        check("t2_cyc_cycles", 64'(cyc_cycles), 64'(2 * XFER_PER_WORD * 4));
        check("t2_done_cnt", 64'(done_cnt), 64'd1);
        toggle_mode = 0;

        // len=1, slave never acks: timeout after 255 wait cycles
        clear_stats();
        ack_delay = -1;
        bq = '{8'hAA, 8'h55};
        pulse_start(12'd1);
        wait_quiet(600, "t3");
        check("t3_cyc_cycles", 64'(cyc_cycles), 64'd255);
        check("t3_status", {busy, err}, 64'b01);
        check("t3_done_cnt", 64'(done_cnt), 64'd0);
        check("t3_wr_count", 64'(wr_adr.size()), 64'd0);

        // start with len=0 clears err and pulses done the next cycle
        clear_stats();
        ack_delay = 0;
        pulse_start(12'd0);
        check("t4_len0_flags", {done, busy, err}, 64'b100);
        @(negedge clk);
        check("t4_len0_done_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("t4_len0_no_bus", 64'(cyc_cycles), 64'd0);

        // second start during a running load is ignored
        clear_stats();
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pulse_start(12'd2);
        repeat (3) @(negedge clk);
        pulse_start(12'd3);
        wait_quiet(200, "t5");
        check("t5_wr_count", 64'(wr_adr.size()), 64'd2);
        if (wr_dat.size() == 2)
            check("t5_words", {wr_dat[0], wr_dat[1]}, {32'h0000_0201, 32'h0000_0403});
        check("t5_done_cnt", 64'(done_cnt), 64'd1);
        check("t5_leftover_bytes", 64'(bq.size()), 64'd2);
        bq.delete();
        repeat (2) @(negedge clk);

`ifdef LOADER_READBACK_EN
        // corrupted echo aborts after word 0
        clear_stats();
        corrupt = 16'h0001;
        bq = '{8'h34, 8'h12, 8'h78, 8'h56};
        pulse_start(12'd2);
        wait_quiet(200, "rb_bad");
        check("rb_bad_counts", {32'(wr_adr.size()), 32'(rd_adr.size())}, {32'd1, 32'd1});
        if (rd_adr.size() > 0) check("rb_bad_rd_adr", 64'(rd_adr[0]), 64'h3000_0000);
        check("rb_bad_status", {busy, err, 32'(done_cnt)}, {2'b01, 32'd0});
        bq.delete();
        // correct echo completes normally
        clear_stats();
        corrupt = '0;
        bq = '{8'h34, 8'h12, 8'h78, 8'h56};
        pulse_start(12'd2);
        wait_quiet(200, "rb_ok");
        check("rb_ok_counts", {32'(wr_adr.size()), 32'(rd_adr.size())}, {32'd2, 32'd2});
        check("rb_ok_status", {busy, err, 32'(done_cnt)}, {2'b00, 32'd1});
`endif

        // reset asserted mid-WAIT drops the bus asynchronously
        clear_stats();
        ack_delay = -1;
        bq = '{8'hAA, 8'h55};
        pulse_start(12'd1);
        for (int i = 0; i < 20 && !wbm_cyc_o; i++) @(negedge clk);
        check("t6_cyc_before_rst", 64'(wbm_cyc_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_drop", {wbm_cyc_o, wbm_stb_o, busy}, 64'b000);
        @(negedge clk);
        bq.delete();
        ack_delay = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_after_rst", {err, busy, wbm_cyc_o, byte_ready, 32'(done_cnt)}, '0);
        pulse_start(12'd0);
        check("t6_idle_len0_done", 64'(done), 64'd1);

        // start coincident with the reset release edge is ignored
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        len   = 12'd1;
        @(posedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        repeat (3) @(negedge clk);
        check("t7_start_at_release", {busy, byte_ready, wbm_cyc_o}, 64'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
